ram_1port_arbiter: RTL and testbench
====================================

Name: ram_1port_arbiter

Overview:
Controller that sits directly upstream of the single-port RAM and owns its only port. It initialises every RAM word after reset. It then arbitrates between an independent write requester and an independent read requester using a req/ack handshake with round-robin priority. Read data returned by the RAM is forwarded to the read requester.

Parameters:
WIDTH, 8, data word width in bits
DEPTH, 4, number of RAM words; address width is $clog2(DEPTH)
INIT_VALUE, 0, word written to every address during initialisation (WIDTH bits)

Ports:
i_Clk  in  1  system clock, all logic on rising edge
i_Rst_L  in  1  asynchronous, active-low reset
i_Wr_Req  in  1  write request, held until o_Wr_Ack
i_Wr_Addr  in  $clog2(DEPTH)  write address
i_Wr_Data  in  WIDTH  write data
o_Wr_Ack  out  1  one-cycle pulse: write accepted
i_Rd_Req  in  1  read request, held until o_Rd_Ack
i_Rd_Addr  in  $clog2(DEPTH)  read address
o_Rd_Ack  out  1  one-cycle pulse: read accepted
o_Rd_DV  out  1  read data valid, one cycle
o_Rd_Data  out  WIDTH  read data, valid when o_Rd_DV
o_Init_Done  out  1  high once initialisation has finished
o_Ram_Addr  out  $clog2(DEPTH)  to RAM i_Addr
o_Ram_Wr_DV  out  1  to RAM i_Wr_DV
o_Ram_Wr_Data  out  WIDTH  to RAM i_Wr_Data
o_Ram_Rd_En  out  1  to RAM i_Rd_En
i_Ram_Rd_DV  in  1  from RAM o_Rd_DV; asserted one clock after Rd_En is sampled
i_Ram_Rd_Data  in  WIDTH  from RAM o_Rd_Data

Behaviour:
- Reset (async assert, sync-released logic): all outputs 0, state INIT, init counter 0, round-robin pointer = write-first, read-pending flag 0.
- FSM has two states, INIT and RUN.
- INIT, per cycle:
  - Register o_Ram_Wr_DV=1, o_Ram_Addr=counter, o_Ram_Wr_Data=INIT_VALUE.
  - Counter increments by 1.
  - After address DEPTH-1 is issued, go to RUN.
  - Takes exactly DEPTH cycles. Both acks stay 0 and requests are ignored (they remain pending).
- RUN:
  - o_Init_Done=1 from the first RUN cycle onward.
- Eligibility:
  - A port is eligible when its Req is high and its own Ack is not high this cycle. This mask prevents double acceptance of a held request.
- Grant:
  - Only one eligible port: grant it.
  - Both eligible: grant the port not granted last (round-robin pointer). The pointer updates only on grant.
- Registered outputs on a grant edge N, visible in the cycle after N:
  - Write grant: o_Ram_Wr_DV=1, o_Ram_Addr=i_Wr_Addr, o_Ram_Wr_Data=i_Wr_Data, o_Wr_Ack=1.
  - Read grant: o_Ram_Rd_En=1, o_Ram_Addr=i_Rd_Addr, o_Rd_Ack=1, read-pending set.
  - No grant: o_Ram_Wr_DV=o_Ram_Rd_En=0; address and data hold their previous values.
- Latency:
  - Ack follows the request by 1 cycle.
  - The RAM samples at edge N+1, so o_Rd_DV is high in the cycle after edge N+1, i.e. one cycle after o_Rd_Ack.
  - Throughput: one RAM operation per cycle overall; each port is limited to one accept every 2 cycles.
- Read return:
  - o_Rd_Data = i_Ram_Rd_Data (combinational).
  - o_Rd_DV = i_Ram_Rd_DV & read-pending.
  - read-pending clears on the cycle i_Ram_Rd_DV is seen, unless a new read is granted in that same cycle.
- Requester contract: Addr and Data stay stable while Req is high. Req deasserts (or presents the next item) in the Ack cycle.
- Reset mid-operation:
  - Immediately drops all strobes and acks and clears read-pending, so a stale RAM DV is never forwarded.
  - Initialisation reruns.
- Read and write to the same address arriving together: the round-robin order decides. The read returns the old or new value accordingly.

Decomposition:
- Shared package: state enum {INIT, RUN}; grant encoding {GNT_NONE, GNT_WR, GNT_RD}; address-width function.
- One natural sub-module: rr_arbiter_2 (2-requester round-robin with mask inputs and a grant-update strobe).

Test Plan:
(All with WIDTH=8, DEPTH=4, INIT_VALUE=8'hA5.)
- Reset release, no requests -> o_Ram_Wr_DV high for exactly 4 cycles at addresses 0,1,2,3 with data A5; o_Init_Done rises the next cycle; both acks stay 0.
- After init, read addr 2 -> o_Rd_Ack one cycle later, o_Rd_DV with o_Rd_Data=A5 one cycle after that.
- Write 0x11..0x44 to addresses 0..3, then read 0..3 -> reads return 11,22,33,44. Each Ack is a single-cycle pulse and there is no duplicate RAM write while the requester holds Req through its Ack cycle.
- Wr_Req and Rd_Req held continuously with changing addresses -> grants alternate W,R,W,R; one RAM op per cycle; o_Ram_Wr_DV and o_Ram_Rd_En never high together.
- Requests asserted during INIT -> no ack until o_Init_Done; the first grant is the write (write-first pointer after reset).
- Assert i_Rst_L low the cycle after a read Ack -> o_Rd_DV stays 0 despite the RAM's DV; init sequence reruns from address 0.

Source files
------------

// File: rtl/ram_1port_arbiter_pkg.sv
// Shared types for the single-port RAM arbiter: FSM states, grant encoding and the
// address-width helper.
package ram_1port_arbiter_pkg;

  typedef enum logic {
    StInit,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    GntNone,
    GntWr,
    GntRd
  } gnt_e;

  // Requester bit positions in the arbiter request/mask vectors.
  localparam int unsigned ReqWr = 0;
  localparam int unsigned ReqRd = 1;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_1port_arbiter_rr_arbiter_2.sv
// Two-requester round-robin arbiter. A requester whose mask bit is set is not eligible;
// the priority pointer only moves when update_i confirms the grant was taken.
module ram_1port_arbiter_rr_arbiter_2
  import ram_1port_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       update_i,
  output gnt_e       gnt_o
);

  logic rd_first_q, rd_first_d;
  logic wr_elig, rd_elig;
  gnt_e gnt;

  always_comb begin
    wr_elig = req_i[ReqWr] & ~mask_i[ReqWr];
    rd_elig = req_i[ReqRd] & ~mask_i[ReqRd];
    gnt     = GntNone;
    if (wr_elig && rd_elig) begin
      gnt = rd_first_q ? GntRd : GntWr;
    end else if (wr_elig) begin
      gnt = GntWr;
    end else if (rd_elig) begin
      gnt = GntRd;
    end
  end

  // Favour whichever port was not granted most recently.
  always_comb begin
    rd_first_d = rd_first_q;
    if (update_i) begin
      unique case (gnt)
        GntWr:   rd_first_d = 1'b1;
        GntRd:   rd_first_d = 1'b0;
        default: rd_first_d = rd_first_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_first_q <= 1'b0;
    end else begin
      rd_first_q <= rd_first_d;
    end
  end

  assign gnt_o = gnt;

endmodule

// File: rtl/ram_1port_arbiter.sv
// Owns the single RAM port: initialises every word after reset, then arbitrates between a
// write requester and a read requester and forwards returned read data.
module ram_1port_arbiter
  import ram_1port_arbiter_pkg::*;
#(
  parameter int unsigned     WIDTH      = 8,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int unsigned    AW         = addr_width(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Wr_Req,
  input  logic [AW-1:0]    i_Wr_Addr,
  input  logic [WIDTH-1:0] i_Wr_Data,
  output logic             o_Wr_Ack,
  input  logic             i_Rd_Req,
  input  logic [AW-1:0]    i_Rd_Addr,
  output logic             o_Rd_Ack,
  output logic             o_Rd_DV,
  output logic [WIDTH-1:0] o_Rd_Data,
  output logic             o_Init_Done,
  output logic [AW-1:0]    o_Ram_Addr,
  output logic             o_Ram_Wr_DV,
  output logic [WIDTH-1:0] o_Ram_Wr_Data,
  output logic             o_Ram_Rd_En,
  input  logic             i_Ram_Rd_DV,
  input  logic [WIDTH-1:0] i_Ram_Rd_Data
);

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0] ram_wr_data_q, ram_wr_data_d;
  logic             ram_wr_dv_q, ram_wr_dv_d;
  logic             ram_rd_en_q, ram_rd_en_d;
  logic             wr_ack_q, wr_ack_d;
  logic             rd_ack_q, rd_ack_d;
  logic             init_done_q, init_done_d;
  logic             rd_pend_q, rd_pend_d;
  gnt_e             gnt;
  logic [1:0]       arb_req, arb_mask;

  // Requests stay pending (not granted) until initialisation is over.
  assign arb_req  = {i_Rd_Req, i_Wr_Req} & {2{state_q == StRun}};
  // A port acked this cycle is still holding its request; do not accept it twice.
  assign arb_mask = {rd_ack_q, wr_ack_q};

  ram_1port_arbiter_rr_arbiter_2 u_rr (
    .clk_i    (i_Clk),
    .rst_ni   (i_Rst_L),
    .req_i    (arb_req),
    .mask_i   (arb_mask),
    .update_i (gnt != GntNone),
    .gnt_o    (gnt)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= StInit;
      cnt_q         <= '0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_wr_dv_q   <= 1'b0;
      ram_rd_en_q   <= 1'b0;
      wr_ack_q      <= 1'b0;
      rd_ack_q      <= 1'b0;
      init_done_q   <= 1'b0;
      rd_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ram_addr_q    <= ram_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
      ram_wr_dv_q   <= ram_wr_dv_d;
      ram_rd_en_q   <= ram_rd_en_d;
      wr_ack_q      <= wr_ack_d;
      rd_ack_q      <= rd_ack_d;
      init_done_q   <= init_done_d;
      rd_pend_q     <= rd_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun:   state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    ram_addr_d    = ram_addr_q;
    ram_wr_data_d = ram_wr_data_q;
    ram_wr_dv_d   = 1'b0;
    ram_rd_en_d   = 1'b0;
    wr_ack_d      = 1'b0;
    rd_ack_d      = 1'b0;
    init_done_d   = (state_q == StRun);
    rd_pend_d     = rd_pend_q & ~i_Ram_Rd_DV;
    unique case (state_q)
      StInit: begin
        ram_wr_dv_d   = 1'b1;
        ram_addr_d    = cnt_q;
        ram_wr_data_d = INIT_VALUE;
      end
      StRun: begin
        unique case (gnt)
          GntWr: begin
            ram_wr_dv_d   = 1'b1;
            ram_addr_d    = i_Wr_Addr;
            ram_wr_data_d = i_Wr_Data;
            wr_ack_d      = 1'b1;
          end
          GntRd: begin
            ram_rd_en_d = 1'b1;
            ram_addr_d  = i_Rd_Addr;
            rd_ack_d    = 1'b1;
            rd_pend_d   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign o_Wr_Ack      = wr_ack_q;
  assign o_Rd_Ack      = rd_ack_q;
  assign o_Init_Done   = init_done_q;
  assign o_Ram_Addr    = ram_addr_q;
  assign o_Ram_Wr_DV   = ram_wr_dv_q;
  assign o_Ram_Wr_Data = ram_wr_data_q;
  assign o_Ram_Rd_En   = ram_rd_en_q;
  assign o_Rd_Data     = i_Ram_Rd_Data;
  // Only forward RAM data for a read this controller actually issued.
  assign o_Rd_DV       = i_Ram_Rd_DV & rd_pend_q;

endmodule

// File: tb/tb_ram_1port_arbiter.sv
// Bench for ram_1port_arbiter with an attached single-port RAM and a word-array/queue
// reference model of what each requester should observe.
module tb_ram_1port_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  INIT  = 8'hA5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0, rd_req = 1'b0;
  logic [1:0] wr_addr = '0, rd_addr = '0;
  logic [7:0] wr_data = '0;
  logic       wr_ack, rd_ack, rd_dv, init_done;
  logic [7:0] rd_data;
  logic [1:0] ram_addr;
  logic       ram_wr_dv, ram_rd_en;
  logic [7:0] ram_wr_data;

  // RAM attached to the controller (environment, not the reference model).
  logic [7:0] ram_mem [DEPTH];
  logic       ram_dv;
  logic [7:0] ram_q;
  int         ram_wr_cnt = 0;

  logic [7:0] model_mem [DEPTH];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_1port_arbiter #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Wr_Req      (wr_req),
    .i_Wr_Addr     (wr_addr),
    .i_Wr_Data     (wr_data),
    .o_Wr_Ack      (wr_ack),
    .i_Rd_Req      (rd_req),
    .i_Rd_Addr     (rd_addr),
    .o_Rd_Ack      (rd_ack),
    .o_Rd_DV       (rd_dv),
    .o_Rd_Data     (rd_data),
    .o_Init_Done   (init_done),
    .o_Ram_Addr    (ram_addr),
    .o_Ram_Wr_DV   (ram_wr_dv),
    .o_Ram_Wr_Data (ram_wr_data),
    .o_Ram_Rd_En   (ram_rd_en),
    .i_Ram_Rd_DV   (ram_dv),
    .i_Ram_Rd_Data (ram_q)
  );

  always @(posedge clk) begin
    if (ram_wr_dv === 1'b1) begin
      ram_mem[ram_addr] <= ram_wr_data;
      ram_wr_cnt        <= ram_wr_cnt + 1;
    end
    ram_dv <= (ram_rd_en === 1'b1);
    if (ram_rd_en === 1'b1) ram_q <= ram_mem[ram_addr];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs from the first edge after reset release until o_Init_Done rises.
  task automatic check_init_seq(input string name);
    int wr_seen = 0;
    int done_cyc = -1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (init_done === 1'b1) begin
        done_cyc = c;
        break;
      end
      total++;
      if (ram_wr_dv !== 1'b1 || ram_addr !== 2'(wr_seen) || ram_wr_data !== INIT) begin
        bad++;
        $display("FAIL %s init write %0d: got dv=%b addr=%0d data=%h want dv=1 addr=%0d data=%h",
                 name, wr_seen, ram_wr_dv, ram_addr, ram_wr_data, wr_seen, INIT);
      end
      total++;
      if ((wr_ack | rd_ack) !== 1'b0) begin
        bad++;
        $display("FAIL %s ack during init: got wr=%b rd=%b want 0", name, wr_ack, rd_ack);
      end
      wr_seen++;
    end
    total++;
    if (wr_seen != DEPTH || done_cyc != DEPTH + 1) begin
      bad++;
      $display("FAIL %s init length: got writes=%0d done_cycle=%0d want writes=%0d done_cycle=%0d",
               name, wr_seen, done_cyc, DEPTH, DEPTH + 1);
    end
  endtask

  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input string name);
    int lat = 0;
    int cnt0 = ram_wr_cnt;
    wr_addr = a;
    wr_data = d;
    wr_req  = 1'b1;
    while (lat < 8) begin
      step();
      lat++;
      if (wr_ack === 1'b1) break;
    end
    total++;
    if (wr_ack !== 1'b1 || lat != 1) begin
      bad++;
      $display("FAIL %s wr ack latency: got ack=%b lat=%0d want ack=1 lat=1", name, wr_ack, lat);
    end
    model_mem[a] = d;
    step();
    total++;
    if (wr_ack !== 1'b0) begin
      bad++;
      $display("FAIL %s wr ack pulse: got %b want 0", name, wr_ack);
    end
    wr_req = 1'b0;
    step();
    total++;
    if (ram_wr_cnt - cnt0 != 1) begin
      bad++;
      $display("FAIL %s ram writes: got %0d want 1", name, ram_wr_cnt - cnt0);
    end
  endtask

  task automatic do_read(input logic [1:0] a, input string name);
    int lat = 0;
    logic [7:0] exp_d;
    rd_addr = a;
    rd_req  = 1'b1;
    while (lat < 8) begin
      step();
      lat++;
      if (rd_ack === 1'b1) break;
    end
    total++;
    if (rd_ack !== 1'b1 || lat != 1) begin
      bad++;
      $display("FAIL %s rd ack latency: got ack=%b lat=%0d want ack=1 lat=1", name, rd_ack, lat);
    end
    exp_d = model_mem[a];
    step();
    total++;
    if (rd_dv !== 1'b1 || rd_data !== exp_d || rd_ack !== 1'b0) begin
      bad++;
      $display("FAIL %s rd data: got dv=%b data=%h ack=%b want dv=1 data=%h ack=0",
               name, rd_dv, rd_data, rd_ack, exp_d);
    end
    rd_req = 1'b0;
    step();
    total++;
    if (rd_dv !== 1'b0) begin
      bad++;
      $display("FAIL %s duplicate read: got dv=%b want 0", name, rd_dv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++;
    if ({wr_ack, rd_ack, rd_dv, init_done, ram_wr_dv, ram_rd_en, ram_addr, ram_wr_data} !== '0) begin
      bad++;
      $display("FAIL reset outputs: got %b want all zero",
               {wr_ack, rd_ack, rd_dv, init_done, ram_wr_dv, ram_rd_en, ram_addr, ram_wr_data});
    end
    rst_n = 1'b1;
    check_init_seq("reset");
    step();
    total++;
    if ({init_done, wr_ack, rd_ack, ram_wr_dv, ram_rd_en} !== 5'b10000) begin
      bad++;
      $display("FAIL idle after init: got %b want 10000",
               {init_done, wr_ack, rd_ack, ram_wr_dv, ram_rd_en});
    end
  endtask

  task automatic test_write_read();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_read(2'd2, "read_init");
    for (int i = 0; i < 4; i++) do_write(2'(i), vals[i], "wr_seq");
    for (int i = 0; i < 4; i++) do_read(2'(i), "rd_seq");
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [$];
    int last = -1;
    int cur;
    wr_addr = 2'($urandom_range(0, 3));
    wr_data = 8'($urandom);
    rd_addr = 2'($urandom_range(0, 3));
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    for (int c = 1; c <= 44; c++) begin
      if (c == 41) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
      step();
      total++;
      if ((ram_wr_dv & ram_rd_en) !== 1'b0) begin
        bad++;
        $display("FAIL b2b both strobes cycle %0d: got wr=%b rd=%b", c, ram_wr_dv, ram_rd_en);
      end
      if (rd_dv === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL b2b unexpected rd_dv cycle %0d: got data=%h want no data", c, rd_data);
        end else begin
          logic [7:0] e = exp_q.pop_front();
          if (rd_data !== e) begin
            bad++;
            $display("FAIL b2b rd data cycle %0d: got %h want %h", c, rd_data, e);
          end
        end
      end
      if (c > 40) continue;
      total++;
      if ((wr_ack ^ rd_ack) !== 1'b1 || ram_wr_dv !== wr_ack || ram_rd_en !== rd_ack) begin
        bad++;
        $display("FAIL b2b one op cycle %0d: got ack w=%b r=%b strobe w=%b r=%b want one",
                 c, wr_ack, rd_ack, ram_wr_dv, ram_rd_en);
      end
      cur = -1;
      if (wr_ack === 1'b1) begin
        cur = 0;
        model_mem[wr_addr] = wr_data;
        wr_addr = 2'($urandom_range(0, 3));
        wr_data = 8'($urandom);
      end
      if (rd_ack === 1'b1) begin
        cur = 1;
        exp_q.push_back(model_mem[rd_addr]);
        rd_addr = 2'($urandom_range(0, 3));
      end
      if (cur >= 0) begin
        if (last >= 0) begin
          total++;
          if (cur == last) begin
            bad++;
            $display("FAIL b2b alternation cycle %0d: got port %0d twice want alternate", c, cur);
          end
        end
        last = cur;
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b missing reads: got %0d outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_init_requests();
    rst_n = 1'b0;
    step();
    wr_addr = 2'd1;
    wr_data = 8'h5A;
    rd_addr = 2'd1;
    wr_req  = 1'b1;
    rd_req  = 1'b1;
    step();
    rst_n = 1'b1;
    check_init_seq("init_req");
    total++;
    if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
      bad++;
      $display("FAIL init_req first grant: got wr=%b rd=%b want wr=1 rd=0", wr_ack, rd_ack);
    end
    model_mem[1] = 8'h5A;
    wr_req = 1'b0;
    step();
    total++;
    if (rd_ack !== 1'b1) begin
      bad++;
      $display("FAIL init_req second grant: got rd=%b want 1", rd_ack);
    end
    rd_req = 1'b0;
    step();
    total++;
    if (rd_dv !== 1'b1 || rd_data !== model_mem[1]) begin
      bad++;
      $display("FAIL init_req read: got dv=%b data=%h want dv=1 data=%h", rd_dv, rd_data,
               model_mem[1]);
    end
    step();
  endtask

  task automatic test_reset_midread();
    int lat = 0;
    rd_addr = 2'd3;
    rd_req  = 1'b1;
    while (lat < 8) begin
      step();
      lat++;
      if (rd_ack === 1'b1) break;
    end
    total++;
    if (rd_ack !== 1'b1) begin
      bad++;
      $display("FAIL midreset rd ack: got %b want 1", rd_ack);
    end
    step();
    rst_n = 1'b0;
    #1;
    total++;
    if (ram_dv !== 1'b1 || rd_dv !== 1'b0) begin
      bad++;
      $display("FAIL midreset stale dv: got ram_dv=%b rd_dv=%b want ram_dv=1 rd_dv=0",
               ram_dv, rd_dv);
    end
    total++;
    if ({wr_ack, rd_ack, ram_wr_dv, ram_rd_en, init_done} !== '0) begin
      bad++;
      $display("FAIL midreset outputs: got %b want 00000",
               {wr_ack, rd_ack, ram_wr_dv, ram_rd_en, init_done});
    end
    rd_req = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check_init_seq("rerun");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_init_requests();
    test_back_to_back();
    test_reset_midread();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
